// File: rtl/uart_rx_fifo_if.sv
// Consumer-side bus of uart_rx_fifo: FWFT head handshake, occupancy and error pulses.
// master = receiver side, slave = command decoder side.
interface uart_rx_fifo_if #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 16
);
   logic [DATA_BITS-1:0]         rx_data_o;
   logic                         rx_valid_o;
   logic                         rx_ready_i;
   logic [$clog2(FIFO_DEPTH):0]  fifo_count_o;
   logic                         frame_err_o;
   logic                         parity_err_o;
   logic                         overrun_o;

   modport master (
      output rx_data_o, rx_valid_o, fifo_count_o, frame_err_o, parity_err_o, overrun_o,
      input  rx_ready_i
   );

   modport slave (
      input  rx_data_o, rx_valid_o, fifo_count_o, frame_err_o, parity_err_o, overrun_o,
      output rx_ready_i
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with first-word-fall-through receive FIFO and explicit error pulses.
// Optional parity bit checking is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_fifo #(
   parameter int CLK_HZ     = 50000000,
   parameter int BAUD       = 57600,
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int PARITY_ODD = 0
) (
   input  logic           CLOCK_50,
   input  logic           rst,
   input  logic           uart_rx_i,
   uart_rx_fifo_if.master bus
);
   localparam int TICK_DIV = (CLK_HZ + BAUD*OVERSAMPLE/2) / (BAUD*OVERSAMPLE);
   localparam int TW       = $clog2(TICK_DIV + 1);
   localparam int SW       = $clog2(OVERSAMPLE + 1);
   localparam int BW       = $clog2(DATA_BITS + 1);
   localparam int AW       = $clog2(FIFO_DEPTH);
   localparam int CW       = AW + 1;
   localparam logic [SW-1:0] MID = SW'(OVERSAMPLE/2);

   if (TICK_DIV < 1 || OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 || DATA_BITS < 5 || DATA_BITS > 9 ||
       FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || PARITY_ODD < 0 || PARITY_ODD > 1)
   begin : g_bad_cfg
      $error("uart_rx_fifo: illegal parameter combination");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_RX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   // ---------------- input synchroniser and start-edge detect ----------------
   logic       sync1_q, sync2_q, rx_s;
   logic [1:0] vld_pipe_q;
   logic       rx_prev_q;

   assign rx_s = sync2_q;

   // rx_prev_q only tracks the line once the reset-preset synchroniser has flushed,
   // so a line held low through reset release never looks like a falling edge.
   always_ff @(posedge CLOCK_50) begin
      if (rst) begin
         sync1_q    <= 1'b1;
         sync2_q    <= 1'b1;
         vld_pipe_q <= '0;
         rx_prev_q  <= 1'b0;
      end else begin
         sync1_q    <= uart_rx_i;
         sync2_q    <= sync1_q;
         vld_pipe_q <= {vld_pipe_q[0], 1'b1};
         rx_prev_q  <= vld_pipe_q[1] ? rx_s : 1'b0;
      end
   end

   state_t state_q;
   logic   start_det;

   assign start_det = (state_q == S_IDLE) && rx_prev_q && !rx_s;

   // ---------------- oversample tick generator ----------------
   logic [TW-1:0] tick_cnt_q;
   logic          tick;

   assign tick = (tick_cnt_q == TW'(TICK_DIV - 1));

   always_ff @(posedge CLOCK_50) begin
      if (rst || start_det || tick) tick_cnt_q <= '0;
      else                          tick_cnt_q <= tick_cnt_q + 1'b1;
   end

   // ---------------- frame FSM ----------------
   logic [SW-1:0]        s_cnt_q, s_idx;
   logic [BW-1:0]        bit_cnt_q;
   logic [1:0]           smp_q;
   logic [DATA_BITS-1:0] shreg_q;
   logic                 push_q, frame_err_q;
   logic                 maj, at_vote, bit_end;

   // s_idx is the tick index within the current bit, 1..OVERSAMPLE
   assign s_idx   = s_cnt_q + 1'b1;
   assign at_vote = (s_idx == MID + 1'b1);
   assign bit_end = (s_idx == SW'(OVERSAMPLE));
   assign maj     = (smp_q[1] & smp_q[0]) | (smp_q[1] & rx_s) | (smp_q[0] & rx_s);

`ifdef UART_RX_PARITY_EN
   localparam logic PAR_ODD = (PARITY_ODD != 0);
   logic par_err_q, par_pulse_q;
`endif

   always_ff @(posedge CLOCK_50) begin
      if (rst) begin
         state_q     <= S_IDLE;
         s_cnt_q     <= '0;
         bit_cnt_q   <= '0;
         smp_q       <= '0;
         shreg_q     <= '0;
         push_q      <= 1'b0;
         frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_err_q   <= 1'b0;
         par_pulse_q <= 1'b0;
`endif
      end else begin
         push_q      <= 1'b0;
         frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_pulse_q <= 1'b0;
`endif
         if (state_q == S_IDLE) begin
            if (start_det) begin
               state_q   <= S_START;
               s_cnt_q   <= '0;
               bit_cnt_q <= '0;
`ifdef UART_RX_PARITY_EN
               par_err_q <= 1'b0;
`endif
            end
         end else if (tick) begin
            smp_q   <= {smp_q[0], rx_s};
            s_cnt_q <= bit_end ? '0 : s_idx;
            case (state_q)
               S_START: begin
                  if (at_vote) state_q <= maj ? S_IDLE : S_DATA;
               end
               S_DATA: begin
                  if (at_vote) begin
                     shreg_q   <= {maj, shreg_q[DATA_BITS-1:1]};
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                  end
`ifdef UART_RX_PARITY_EN
                  if (bit_end && bit_cnt_q == BW'(DATA_BITS)) state_q <= S_PARITY;
               end
               S_PARITY: begin
                  if (at_vote) par_err_q <= maj ^ (^shreg_q) ^ PAR_ODD;
                  if (bit_end) state_q <= S_STOP;
`else
                  if (bit_end && bit_cnt_q == BW'(DATA_BITS)) state_q <= S_STOP;
`endif
               end
               S_STOP: begin
                  // leave at mid-stop so the next start edge is caught even back-to-back
                  if (s_idx == MID) begin
                     state_q <= S_IDLE;
                     if (!rx_s) frame_err_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
                     else if (par_err_q) par_pulse_q <= 1'b1;
`endif
                     else push_q <= 1'b1;
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   // ---------------- receive FIFO (FWFT, registered head) ----------------
   logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr_q, rd_ptr_q, rd_inc;
   logic [CW-1:0]        count_q, count_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 overrun_q;
   logic                 full, pop, wr_en;

   assign full   = (count_q == CW'(FIFO_DEPTH));
   assign pop    = (count_q != '0) && bus.rx_ready_i;
   assign wr_en  = push_q && (!full || pop);
   assign rd_inc = rd_ptr_q + 1'b1;

   always_comb begin
      count_d = count_q;
      if (wr_en && !pop)      count_d = count_q + 1'b1;
      else if (!wr_en && pop) count_d = count_q - 1'b1;
      data_d = data_q;
      if (pop && count_q > CW'(1))           data_d = mem_q[rd_inc];
      else if (wr_en && (count_q == '0 || pop)) data_d = shreg_q;
   end

   always_ff @(posedge CLOCK_50) begin
      if (wr_en) mem_q[wr_ptr_q] <= shreg_q;
   end

   always_ff @(posedge CLOCK_50) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         data_q    <= '0;
         overrun_q <= 1'b0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)   rd_ptr_q <= rd_inc;
         count_q   <= count_d;
         data_q    <= data_d;
         overrun_q <= push_q && full && !pop;
      end
   end

   assign bus.rx_data_o    = data_q;
   assign bus.rx_valid_o   = (count_q != '0);
   assign bus.fifo_count_o = count_q;
   assign bus.frame_err_o  = frame_err_q;
   assign bus.overrun_o    = overrun_q;
`ifdef UART_RX_PARITY_EN
   assign bus.parity_err_o = par_pulse_q;
`else
   assign bus.parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: reset, reception, frame/parity errors, overrun,
// full push+pop, glitch rejection and mid-frame reset.
module tb_uart_rx_fifo;
   localparam int CLK_HZ  = 3686400;   // TICK_DIV = 4 at 57600 x16
   localparam int BAUD    = 57600;
   localparam int OS      = 16;
   localparam int DB      = 8;
   localparam int DEPTH   = 16;
   localparam int BIT_CYC = 4 * OS;
`ifdef UART_RX_PARITY_EN
   localparam int PRE_STOP = 1 + DB + 1;
   localparam logic PAR_ODD = 1'b0;
   logic par_flip = 1'b0;
`else
   localparam int PRE_STOP = 1 + DB;
`endif
   // start reaches the FSM 3 edges after the line falls, ticks every 4 cycles after that
   localparam int PUSH_CYC = 3 + 4*(PRE_STOP*OS + OS/2) + 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic uart_rx = 1'b1;
   int   checks = 0;
   int   failures = 0;
   int   n_ferr = 0, n_perr = 0, n_ovr = 0;

   always #5 clk = ~clk;

   uart_rx_fifo_if #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH)) bus ();

   uart_rx_fifo #(
      .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(DB),
      .FIFO_DEPTH(DEPTH), .PARITY_ODD(0)
   ) dut (
      .CLOCK_50 (clk),
      .rst      (rst),
      .uart_rx_i(uart_rx),
      .bus      (bus)
   );

   always @(negedge clk) begin
      if (bus.frame_err_o)  n_ferr++;
      if (bus.parity_err_o) n_perr++;
      if (bus.overrun_o)    n_ovr++;
   end

   initial begin
      #600000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_b);
      uart_rx = 1'b0;
      wait_cyc(BIT_CYC);
      for (int i = 0; i < DB; i++) begin
         uart_rx = d[i];
         wait_cyc(BIT_CYC);
      end
`ifdef UART_RX_PARITY_EN
      uart_rx = (^d) ^ PAR_ODD ^ par_flip;
      wait_cyc(BIT_CYC);
`endif
      uart_rx = stop_b;
      wait_cyc(BIT_CYC);
      uart_rx = 1'b1;
   endtask

   task automatic pop_one();
      bus.rx_ready_i = 1'b1;
      wait_cyc(1);
      bus.rx_ready_i = 1'b0;
   endtask

   task automatic test_reset();
      bus.rx_ready_i = 1'b0;
      rst = 1'b1;
      wait_cyc(4);
      rst = 1'b0;
      wait_cyc(1);
      checks++; if (bus.rx_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b want=0", bus.rx_valid_o); end
      checks++; if (bus.fifo_count_o !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d want=0", bus.fifo_count_o); end
      checks++; if (bus.rx_data_o !== 8'h00) begin failures++; $display("FAIL reset_data got=%h want=00", bus.rx_data_o); end
      checks++; if ({bus.frame_err_o, bus.parity_err_o, bus.overrun_o} !== 3'b000) begin failures++;
         $display("FAIL reset_errs got=%b want=000", {bus.frame_err_o, bus.parity_err_o, bus.overrun_o}); end
   endtask

   task automatic test_basic();
      int f0 = n_ferr, p0 = n_perr;
      send_frame(8'h55, 1'b1);
      checks++; if (bus.rx_valid_o !== 1'b1) begin failures++; $display("FAIL basic_valid got=%0b want=1", bus.rx_valid_o); end
      checks++; if (bus.rx_data_o !== 8'h55) begin failures++; $display("FAIL basic_data got=%h want=55", bus.rx_data_o); end
      checks++; if (bus.fifo_count_o !== 5'd1) begin failures++; $display("FAIL basic_count got=%0d want=1", bus.fifo_count_o); end
      checks++; if (n_ferr - f0 + n_perr - p0 != 0) begin failures++; $display("FAIL basic_errs got=%0d want=0", n_ferr - f0 + n_perr - p0); end
      pop_one();
      checks++; if (bus.fifo_count_o !== 5'd0 || bus.rx_valid_o !== 1'b0) begin failures++;
         $display("FAIL basic_pop count=%0d valid=%0b want 0/0", bus.fifo_count_o, bus.rx_valid_o); end
   endtask

   task automatic test_frame_err();
      int f0 = n_ferr, p0 = n_perr;
      send_frame(8'h55, 1'b0);
      wait_cyc(BIT_CYC);
      checks++; if (n_ferr - f0 != 1) begin failures++; $display("FAIL ferr_pulses got=%0d want=1", n_ferr - f0); end
      checks++; if (n_perr - p0 != 0) begin failures++; $display("FAIL ferr_perr got=%0d want=0", n_perr - p0); end
      checks++; if (bus.fifo_count_o !== 5'd0) begin failures++; $display("FAIL ferr_count got=%0d want=0", bus.fifo_count_o); end
   endtask

   task automatic test_patterns();
      send_frame(8'h3C, 1'b1);
      send_frame(8'hC3, 1'b1);
      checks++; if (bus.fifo_count_o !== 5'd2) begin failures++; $display("FAIL pat_count got=%0d want=2", bus.fifo_count_o); end
      checks++; if (bus.rx_data_o !== 8'h3C) begin failures++; $display("FAIL pat_head0 got=%h want=3c", bus.rx_data_o); end
      pop_one();
      checks++; if (bus.rx_data_o !== 8'hC3) begin failures++; $display("FAIL pat_head1 got=%h want=c3", bus.rx_data_o); end
      pop_one();
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity();
      int f0 = n_ferr, p0 = n_perr;
      send_frame(8'h55, 1'b1);
      checks++; if (bus.fifo_count_o !== 5'd1 || bus.rx_data_o !== 8'h55) begin failures++;
         $display("FAIL par_good count=%0d data=%h want 1/55", bus.fifo_count_o, bus.rx_data_o); end
      pop_one();
      par_flip = 1'b1;
      send_frame(8'h55, 1'b1);
      par_flip = 1'b0;
      checks++; if (n_perr - p0 != 1) begin failures++; $display("FAIL par_pulses got=%0d want=1", n_perr - p0); end
      checks++; if (n_ferr - f0 != 0) begin failures++; $display("FAIL par_ferr got=%0d want=0", n_ferr - f0); end
      checks++; if (bus.fifo_count_o !== 5'd0) begin failures++; $display("FAIL par_count got=%0d want=0", bus.fifo_count_o); end
   endtask
`endif

   task automatic test_overrun();
      int o0 = n_ovr;
      for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b1);
      checks++; if (bus.fifo_count_o !== 5'd16 || n_ovr != o0) begin failures++;
         $display("FAIL ovr_fill count=%0d ovr=%0d want 16/0", bus.fifo_count_o, n_ovr - o0); end
      send_frame(8'h10, 1'b1);
      checks++; if (n_ovr - o0 != 1) begin failures++; $display("FAIL ovr_pulses got=%0d want=1", n_ovr - o0); end
      checks++; if (bus.fifo_count_o !== 5'd16) begin failures++; $display("FAIL ovr_count got=%0d want=16", bus.fifo_count_o); end
      for (int i = 0; i < 16; i++) begin
         checks++; if (bus.rx_valid_o !== 1'b1 || bus.rx_data_o !== 8'(i)) begin failures++;
            $display("FAIL ovr_drain%0d valid=%0b data=%h want 1/%h", i, bus.rx_valid_o, bus.rx_data_o, 8'(i)); end
         pop_one();
      end
      checks++; if (bus.rx_valid_o !== 1'b0 || bus.fifo_count_o !== 5'd0) begin failures++;
         $display("FAIL ovr_empty valid=%0b count=%0d want 0/0", bus.rx_valid_o, bus.fifo_count_o); end
   endtask

   task automatic test_full_pop();
      int o0;
      for (int i = 0; i < 16; i++) send_frame(8'h20 + 8'(i), 1'b1);
      o0 = n_ovr;
      fork
         send_frame(8'h30, 1'b1);
         begin
            wait_cyc(PUSH_CYC - 1);
            checks++; if (bus.rx_data_o !== 8'h20) begin failures++; $display("FAIL full_head got=%h want=20", bus.rx_data_o); end
            pop_one();
         end
      join
      checks++; if (n_ovr != o0) begin failures++; $display("FAIL full_ovr got=%0d want=0", n_ovr - o0); end
      checks++; if (bus.fifo_count_o !== 5'd16) begin failures++; $display("FAIL full_count got=%0d want=16", bus.fifo_count_o); end
      for (int i = 0; i < 16; i++) begin
         checks++; if (bus.rx_data_o !== 8'h21 + 8'(i)) begin failures++;
            $display("FAIL full_drain%0d got=%h want=%h", i, bus.rx_data_o, 8'h21 + 8'(i)); end
         pop_one();
      end
   endtask

   task automatic test_glitch();
      int f0 = n_ferr, p0 = n_perr;
      uart_rx = 1'b0;
      wait_cyc(BIT_CYC/2);
      uart_rx = 1'b1;
      wait_cyc(12*BIT_CYC);
      checks++; if (bus.fifo_count_o !== 5'd0) begin failures++; $display("FAIL glitch_count got=%0d want=0", bus.fifo_count_o); end
      checks++; if (n_ferr - f0 + n_perr - p0 != 0) begin failures++; $display("FAIL glitch_errs got=%0d want=0", n_ferr - f0 + n_perr - p0); end
   endtask

   task automatic test_reset_mid();
      int f0;
      send_frame(8'h11, 1'b1);
      uart_rx = 1'b0;
      wait_cyc(3*BIT_CYC);
      rst = 1'b1;
      wait_cyc(2);
      rst = 1'b0;
      wait_cyc(1);
      checks++; if (bus.fifo_count_o !== 5'd0 || bus.rx_valid_o !== 1'b0 || bus.rx_data_o !== 8'h00) begin failures++;
         $display("FAIL rstmid_clear count=%0d valid=%0b data=%h want 0/0/00", bus.fifo_count_o, bus.rx_valid_o, bus.rx_data_o); end
      f0 = n_ferr;
      wait_cyc(2*BIT_CYC);
      uart_rx = 1'b1;
      wait_cyc(12*BIT_CYC);
      checks++; if (bus.fifo_count_o !== 5'd0 || n_ferr != f0) begin failures++;
         $display("FAIL rstmid_low count=%0d ferr=%0d want 0/0", bus.fifo_count_o, n_ferr - f0); end
      send_frame(8'hA3, 1'b1);
      checks++; if (bus.fifo_count_o !== 5'd1 || bus.rx_data_o !== 8'hA3) begin failures++;
         $display("FAIL rstmid_rx count=%0d data=%h want 1/a3", bus.fifo_count_o, bus.rx_data_o); end
      pop_one();
   endtask

   initial begin
      bus.rx_ready_i = 1'b0;
      test_reset();
      test_basic();
      test_frame_err();
      test_patterns();
`ifdef UART_RX_PARITY_EN
      test_parity();
`endif
      test_overrun();
      test_full_pop();
      test_glitch();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
